// File: rtl/vector_ctrl_pkg.sv
// Shared encodings for the G2 vector-group main decoder: opcodes, ALU ops
// and the bundled control word carried through the pipeline register.
package vector_ctrl_pkg;

  localparam logic [4:0] OP_VADD = 5'b10000;
  localparam logic [4:0] OP_VSUB = 5'b10001;
  localparam logic [4:0] OP_VMUL = 5'b10010;
  localparam logic [4:0] OP_VLDR = 5'b10100;
  localparam logic [4:0] OP_VSTR = 5'b10101;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    vect_dst;
    logic    vector_read;
    logic    mem_write;
    logic    vect_write;
    logic    vect_src1;
    logic    vect_src2;
    logic    illegal;
  } vctrl_t;

  // Unrecognised opcodes decode to a bubble that raises illegal and no strobes
  localparam vctrl_t VCTRL_NOP = '{
    alu_op: ALU_ADD, vect_dst: 1'b0, vector_read: 1'b0, mem_write: 1'b0,
    vect_write: 1'b0, vect_src1: 1'b0, vect_src2: 1'b0, illegal: 1'b1
  };

  // Register contents while held in reset: everything low, illegal included
  localparam vctrl_t VCTRL_RST = '{
    alu_op: ALU_ADD, vect_dst: 1'b0, vector_read: 1'b0, mem_write: 1'b0,
    vect_write: 1'b0, vect_src1: 1'b0, vect_src2: 1'b0, illegal: 1'b0
  };

endpackage

// File: rtl/vector_ctrl_decode.sv
// Combinational opcode-to-control-word decode for the vector datapath group.
module vector_ctrl_decode
  import vector_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output vctrl_t     ctrl
);

  // Map each legal G2 opcode to its control row; all else is a NOP
  always_comb begin
    ctrl = VCTRL_NOP;
    unique case (opcode)
      OP_VADD: ctrl = '{alu_op: ALU_ADD, vect_dst: 1'b1, vector_read: 1'b0, mem_write: 1'b0,
                        vect_write: 1'b1, vect_src1: 1'b1, vect_src2: 1'b1, illegal: 1'b0};
      OP_VSUB: ctrl = '{alu_op: ALU_SUB, vect_dst: 1'b1, vector_read: 1'b0, mem_write: 1'b0,
                        vect_write: 1'b1, vect_src1: 1'b1, vect_src2: 1'b1, illegal: 1'b0};
      OP_VMUL: ctrl = '{alu_op: ALU_MUL, vect_dst: 1'b1, vector_read: 1'b0, mem_write: 1'b0,
                        vect_write: 1'b1, vect_src1: 1'b1, vect_src2: 1'b1, illegal: 1'b0};
      OP_VLDR: ctrl = '{alu_op: ALU_ADD, vect_dst: 1'b1, vector_read: 1'b1, mem_write: 1'b0,
                        vect_write: 1'b1, vect_src1: 1'b0, vect_src2: 1'b0, illegal: 1'b0};
      // Store reads its data from the vector file but writes nothing back
      OP_VSTR: ctrl = '{alu_op: ALU_ADD, vect_dst: 1'b0, vector_read: 1'b0, mem_write: 1'b1,
                        vect_write: 1'b0, vect_src1: 1'b0, vect_src2: 1'b1, illegal: 1'b0};
      default: ctrl = VCTRL_NOP;
    endcase
  end

endmodule

// File: rtl/vector_ctrl_unit.sv
// Vector-group main decoder: combinational decode followed by a single
// pipeline register bank so every control output comes straight from a flop.
module vector_ctrl_unit
  import vector_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] Opcode,
  output logic [1:0] ALU_Vectorial,
  output logic       VectDst,
  output logic       Vector_Read,
  output logic       MemWrite_vector,
  output logic       Vect_Write,
  output logic       Vect_Src1,
  output logic       Vect_Src2,
  output logic       illegal
);

  vctrl_t ctrl_s;
  vctrl_t ctrl_r;

  vector_ctrl_decode u_decode (
    .opcode (Opcode),
    .ctrl   (ctrl_s)
  );

  // Pipeline register: reloads every cycle, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r <= VCTRL_RST;
    end else begin
      ctrl_r <= ctrl_s;
    end
  end

  assign ALU_Vectorial   = ctrl_r.alu_op;
  assign VectDst         = ctrl_r.vect_dst;
  assign Vector_Read     = ctrl_r.vector_read;
  assign MemWrite_vector = ctrl_r.mem_write;
  assign Vect_Write      = ctrl_r.vect_write;
  assign Vect_Src1       = ctrl_r.vect_src1;
  assign Vect_Src2       = ctrl_r.vect_src2;
  assign illegal         = ctrl_r.illegal;

endmodule

// File: tb/tb_vector_ctrl_unit.sv
// Directed self-checking bench for vector_ctrl_unit with an exhaustive opcode sweep.
module tb_vector_ctrl_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] Opcode;
  logic [1:0] ALU_Vectorial;
  logic       VectDst;
  logic       Vector_Read;
  logic       MemWrite_vector;
  logic       Vect_Write;
  logic       Vect_Src1;
  logic       Vect_Src2;
  logic       illegal;

  int checks;
  int errors;

  // Expected rows as {ALU_Vectorial, VectDst, Vector_Read, MemWrite_vector, Vect_Write, Vect_Src1, Vect_Src2, illegal}
  localparam logic [8:0] E_VADD = 9'b00_1001110;
  localparam logic [8:0] E_VSUB = 9'b01_1001110;
  localparam logic [8:0] E_VMUL = 9'b10_1001110;
  localparam logic [8:0] E_VLDR = 9'b00_1101000;
  localparam logic [8:0] E_VSTR = 9'b00_0010010;
  localparam logic [8:0] E_NOP  = 9'b00_0000001;
  localparam logic [8:0] E_RST  = 9'b00_0000000;

  vector_ctrl_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .Opcode          (Opcode),
    .ALU_Vectorial   (ALU_Vectorial),
    .VectDst         (VectDst),
    .Vector_Read     (Vector_Read),
    .MemWrite_vector (MemWrite_vector),
    .Vect_Write      (Vect_Write),
    .Vect_Src1       (Vect_Src1),
    .Vect_Src2       (Vect_Src2),
    .illegal         (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] model(input logic [4:0] op);
    case (op)
      5'd16:   model = E_VADD;
      5'd17:   model = E_VSUB;
      5'd18:   model = E_VMUL;
      5'd20:   model = E_VLDR;
      5'd21:   model = E_VSTR;
      default: model = E_NOP;
    endcase
  endfunction

  function automatic logic [8:0] observed();
    observed = {ALU_Vectorial, VectDst, Vector_Read, MemWrite_vector,
                Vect_Write, Vect_Src1, Vect_Src2, illegal};
  endfunction

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] obs;
    logic       inv_ok;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
    inv_ok = !(MemWrite_vector && Vect_Write) &&
             (!Vector_Read || (Vect_Write && VectDst)) &&
             (!illegal || (!MemWrite_vector && !Vect_Write));
    checks++;
    assert (inv_ok === 1'b1) else begin
      errors++;
      $error("FAIL %s_invariant observed %b expected 1", tag, inv_ok);
    end
  endtask

  // Drive at the falling edge, let the rising edge load, sample at the next falling edge
  task automatic step(input logic [4:0] op, input string tag, input logic [8:0] exp);
    Opcode = op;
    @(negedge clk);
    check(tag, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    Opcode = 5'b10000;

    // Reset held over several edges
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", E_RST);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_vadd", E_VADD);

    // Arithmetic
    step(5'b10000, "vadd", E_VADD);
    step(5'b10001, "vsub", E_VSUB);
    step(5'b10010, "vmul", E_VMUL);

    // Memory
    step(5'b10100, "vldr", E_VLDR);
    step(5'b10101, "vstr", E_VSTR);

    // Illegal
    step(5'b11111, "illegal_11111", E_NOP);
    step(5'b10011, "illegal_10011", E_NOP);
    step(5'b00000, "illegal_00000", E_NOP);
    step(5'b10110, "illegal_10110", E_NOP);

    // Async reset between edges while VSTR is registered
    step(5'b10101, "vstr_pre_reset", E_VSTR);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_clear", E_RST);
    @(negedge clk);
    check("async_reset_hold", E_RST);
    rst_n = 1'b1;
    step(5'b10001, "post_reset_vsub", E_VSUB);

    // Exhaustive sweep
    for (int op = 0; op < 32; op++) begin
      step(op[4:0], $sformatf("sweep_%02h", op), model(op[4:0]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
